// File: rtl/uart_tx.sv
// FIFO-buffered 8N1 UART transmitter with a registered serial output.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frame).
module uart_tx #(
    parameter int BAUD_CNT_END = 5207,
    parameter int FIFO_AW      = 3
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       fifo_full,
    output logic       tx_ovf,
    output logic       tx_busy,
    output logic       rs232_tx
);

    localparam int CW    = (BAUD_CNT_END > 0) ? $clog2(BAUD_CNT_END + 1) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] CNT_END = CW'(BAUD_CNT_END);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               tx_q;
    logic               ovf_q;
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         mem [DEPTH];
`ifdef UART_TX_PARITY_EN
    logic               parity_q;
`endif

    logic       fifo_empty;
    logic       full;
    logic       push;
    logic       pop;
    logic       bit_end;
    logic [7:0] rd_data;

    // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        bit_end    = (cnt_q == CNT_END);
        push       = pi_flag && !full;
        pop        = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end));
        rd_data    = mem[rd_ptr_q[FIFO_AW-1:0]];
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= pi_flag && full;
        end
    end

    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= pi_data;
        end
    end

    // The line register follows the state one cycle later, so every bit keeps its full width.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            cnt_q <= ((state_q == IDLE) || bit_end) ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state_q  <= START;
                        shift_q  <= rd_data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^rd_data;
`endif
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_q <= parity_q;
                    if (bit_end) begin
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        if (pop) begin
                            state_q  <= START;
                            shift_q  <= rd_data;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^rd_data;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_full = full;
    assign tx_ovf    = ovf_q;
    assign tx_busy   = (state_q != IDLE);
    assign rs232_tx  = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a short bit period; a line monitor decodes frames
// into queues that the main sequence compares against hand-computed bytes.
module tb_uart_tx;

    localparam int BIT_END = 7;
    localparam int BIT     = BIT_END + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BIT;

    logic       sclk;
    logic       s_rst_n;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic       fifo_full;
    logic       tx_ovf;
    logic       tx_busy;
    logic       rs232_tx;

    int totalChecks = 0;
    int badChecks   = 0;
    int cyc         = 0;

    logic [7:0] rxByteQ [$];
    logic       rxStartQ[$];
    logic       rxParQ  [$];
    logic       rxStopQ [$];
    int         rxTimeQ [$];

    uart_tx #(.BAUD_CNT_END(BIT_END), .FIFO_AW(3)) dut (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .pi_data  (pi_data),
        .pi_flag  (pi_flag),
        .fifo_full(fifo_full),
        .tx_ovf   (tx_ovf),
        .tx_busy  (tx_busy),
        .rs232_tx (rs232_tx)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    // Receiver model: detects the start edge on a falling clock and samples each bit mid-period.
    logic [7:0] monByte;
    logic       monStart, monPar, monStop;
    int         monTime;
    always begin
        @(negedge sclk);
        if (s_rst_n === 1'b1 && rs232_tx === 1'b0) begin
            monTime = cyc;
            repeat (BIT / 2) @(negedge sclk);
            monStart = rs232_tx;
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge sclk);
                monByte[i] = rs232_tx;
            end
            monPar = 1'b0;
`ifdef UART_TX_PARITY_EN
            repeat (BIT) @(negedge sclk);
            monPar = rs232_tx;
`endif
            repeat (BIT) @(negedge sclk);
            monStop = rs232_tx;
            rxByteQ.push_back(monByte);
            rxStartQ.push_back(monStart);
            rxParQ.push_back(monPar);
            rxStopQ.push_back(monStop);
            rxTimeQ.push_back(monTime);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        assert (obs === exp) else begin
            badChecks++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte for exactly one rising edge; returns on the falling edge after it.
    task automatic applyStimulus(input logic [7:0] b);
        pi_flag = 1'b1;
        pi_data = b;
        @(negedge sclk);
        pi_flag = 1'b0;
        pi_data = 8'hA5 ^ b;
    endtask

    task automatic waitFrames(input string tag, input int n);
        int c = 0;
        while (rxByteQ.size() < n && c < FRAME * (n + 3)) begin
            @(negedge sclk);
            c++;
        end
        checkOutput(tag, 32'(rxByteQ.size() >= n), 32'd1);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] expByte, output int startTime);
        startTime = 0;
        checkOutput({tag, "_present"}, 32'(rxByteQ.size() > 0), 32'd1);
        if (rxByteQ.size() > 0) begin
            logic [7:0] b;
            logic       p;
            b = rxByteQ.pop_front();
            p = rxParQ.pop_front();
            startTime = rxTimeQ.pop_front();
            checkOutput({tag, "_start"}, 32'(rxStartQ.pop_front()), 32'd0);
            checkOutput({tag, "_data"}, 32'(b), 32'(expByte));
            checkOutput({tag, "_stop"}, 32'(rxStopQ.pop_front()), 32'd1);
`ifdef UART_TX_PARITY_EN
            checkOutput({tag, "_par"}, 32'(p), 32'(^expByte));
`else
            checkOutput({tag, "_par"}, 32'(p), 32'd0);
`endif
        end
    endtask

    task automatic clearRx();
        rxByteQ.delete();
        rxStartQ.delete();
        rxParQ.delete();
        rxStopQ.delete();
        rxTimeQ.delete();
    endtask

    initial begin
        logic [7:0] burst [3];
        int         t [10];
        int         tPrev;

        burst[0] = 8'h00;
        burst[1] = 8'hFF;
        burst[2] = 8'hA5;

        s_rst_n = 1'b0;
        pi_flag = 1'b0;
        pi_data = 8'h00;
        repeat (3) @(negedge sclk);
        checkOutput("rst_tx", 32'(rs232_tx), 32'd1);
        checkOutput("rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("rst_ovf", 32'(tx_ovf), 32'd0);
        checkOutput("rst_full", 32'(fifo_full), 32'd0);
        s_rst_n = 1'b1;
        repeat (5) @(negedge sclk);
        checkOutput("idle_tx", 32'(rs232_tx), 32'd1);
        checkOutput("idle_busy", 32'(tx_busy), 32'd0);

        $display("[TB] single byte 0x55 with latency and busy timing");
        applyStimulus(8'h55);
        checkOutput("k0_busy", 32'(tx_busy), 32'd0);
        checkOutput("k0_tx", 32'(rs232_tx), 32'd1);
        @(negedge sclk);
        checkOutput("k1_busy", 32'(tx_busy), 32'd1);
        checkOutput("k1_tx", 32'(rs232_tx), 32'd1);
        @(negedge sclk);
        checkOutput("k2_tx", 32'(rs232_tx), 32'd0);
        repeat (FRAME - 2) @(negedge sclk);
        checkOutput("end_busy_hi", 32'(tx_busy), 32'd1);
        @(negedge sclk);
        checkOutput("end_busy_lo", 32'(tx_busy), 32'd0);
        waitFrames("wait_single", 1);
        checkFrame("single", 8'h55, t[0]);

        $display("[TB] burst of three back-to-back bytes");
        for (int i = 0; i < 3; i++) applyStimulus(burst[i]);
        waitFrames("wait_burst", 3);
        for (int i = 0; i < 3; i++) checkFrame($sformatf("burst%0d", i), burst[i], t[i]);
        checkOutput("burst_gap1", 32'(t[1] - t[0]), 32'(FRAME));
        checkOutput("burst_gap2", 32'(t[2] - t[1]), 32'(FRAME));

        $display("[TB] overflow with ten consecutive writes");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h30 + 8'(i));
            checkOutput($sformatf("ovf_full%0d", i), 32'(fifo_full), 32'(i >= 8));
            checkOutput($sformatf("ovf_pulse%0d", i), 32'(tx_ovf), 32'(i == 9));
        end
        @(negedge sclk);
        checkOutput("ovf_pulse_end", 32'(tx_ovf), 32'd0);
        checkOutput("ovf_full_hold", 32'(fifo_full), 32'd1);
        waitFrames("wait_ovf", 9);
        tPrev = 0;
        for (int i = 0; i < 9; i++) begin
            checkFrame($sformatf("ovf%0d", i), 8'h30 + 8'(i), t[0]);
            if (i > 0) checkOutput($sformatf("ovf_gap%0d", i), 32'(t[0] - tPrev), 32'(FRAME));
            tPrev = t[0];
        end
        repeat (2 * FRAME) @(negedge sclk);
        checkOutput("ovf_no_tenth", 32'(rxByteQ.size()), 32'd0);
        checkOutput("ovf_idle_busy", 32'(tx_busy), 32'd0);
        checkOutput("ovf_full_clear", 32'(fifo_full), 32'd0);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity bits");
        applyStimulus(8'h07);
        waitFrames("wait_par07", 1);
        checkOutput("par07", 32'(rxParQ[0]), 32'd1);
        checkFrame("par07f", 8'h07, t[0]);
        applyStimulus(8'h03);
        waitFrames("wait_par03", 1);
        checkOutput("par03", 32'(rxParQ[0]), 32'd0);
        checkFrame("par03f", 8'h03, t[0]);
`endif

        $display("[TB] reset during data bit 3 with a byte still queued");
        applyStimulus(8'h0F);
        applyStimulus(8'h33);
        repeat (36) @(negedge sclk);
        checkOutput("pre_rst_busy", 32'(tx_busy), 32'd1);
        s_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tx", 32'(rs232_tx), 32'd1);
        checkOutput("mid_rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("mid_rst_full", 32'(fifo_full), 32'd0);
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge sclk);
        clearRx();
        repeat (2 * FRAME) @(negedge sclk);
        checkOutput("post_rst_frames", 32'(rxByteQ.size()), 32'd0);
        checkOutput("post_rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("post_rst_tx", 32'(rs232_tx), 32'd1);

        $display("[TB] paced stream of twenty bytes across pointer wrap");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'(i * 37 + 11));
            checkOutput($sformatf("wrap_nofull%0d", i), 32'(fifo_full), 32'd0);
            repeat (59) @(negedge sclk);
        end
        waitFrames("wait_wrap", 20);
        for (int i = 0; i < 20; i++) checkFrame($sformatf("wrap%0d", i), 8'(i * 37 + 11), t[0]);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter BAUD_CNT_END, default 5207, meaning the last value of the bit-period counter (one bit = BAUD_CNT_END+1 sclk cycles; 9600 baud at 50 MHz).
REQ-002 The block SHALL have parameter FIFO_AW, default 3, meaning FIFO address width (depth = 2^FIFO_AW = 8 bytes).
REQ-003 The block SHALL have port sclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port s_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port pi_data, input, 8 bits: byte to transmit.
REQ-006 The block SHALL have port pi_flag, input, 1 bit: one-cycle write strobe for pi_data.
REQ-007 The block SHALL have port fifo_full, output, 1 bit: FIFO holds 2^FIFO_AW bytes.
REQ-008 The block SHALL have port tx_ovf, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-009 The block SHALL have port tx_busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-010 The block SHALL have port rs232_tx, output, 1 bit: serial line, registered, idle high.

Function
REQ-011 Frame format SHALL be: start bit 0, 8 data bits LSB first, optional parity bit (REQ-026), 1 stop bit 1.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; the transitions are IDLE->START on FIFO non-empty, START->DATA, DATA->PARITY or STOP after bit 7, PARITY->STOP, and STOP->START if FIFO non-empty, else STOP->IDLE.
REQ-013 Each non-IDLE state SHALL last exactly BAUD_CNT_END+1 cycles, and the bit counter SHALL clear on every state change.
REQ-014 The FIFO pop SHALL occur on the IDLE->START or STOP->START transition edge, and the popped byte SHALL be latched into a shift register on that edge.
REQ-015 With FSM in IDLE and FIFO empty, a pi_flag at edge k SHALL cause rs232_tx to go low at edge k+2.
REQ-016 Back-to-back frames SHALL have no idle gap: the start bit immediately follows the stop bit.
REQ-017 A write with fifo_full=1 SHALL be dropped and tx_ovf SHALL pulse on the next cycle, even if a pop occurs on the same edge.
REQ-018 A write and a pop on the same edge with the FIFO not full SHALL both take effect, leaving the count unchanged.
REQ-019 Pointers SHALL be FIFO_AW+1 bits wide, with full/empty decided by the MSB comparison; wrap-around SHALL be lossless.
REQ-020 pi_data SHALL be sampled only on the edge where pi_flag=1, and SHALL be don't-care at all other times.

Reset
REQ-021 While s_rst_n=0, rs232_tx SHALL be 1, tx_busy 0, tx_ovf 0, fifo_full 0, FSM in IDLE, pointers 0, and counters 0, all asynchronously.
REQ-022 A reset mid-frame SHALL abort the frame immediately, with the line high and the FIFO contents discarded.
REQ-023 After release, the first transmission SHALL require a new pi_flag.

Configuration
REQ-024 Macro UART_TX_PARITY_EN SHALL select the parity option.
REQ-025 Without UART_TX_PARITY_EN, the PARITY state SHALL be absent and the frame SHALL be 10 bits.
REQ-026 With UART_TX_PARITY_EN defined, an even-parity bit (XOR of the 8 data bits) SHALL be sent in PARITY, and the frame SHALL be 11 bits.

Verification (BAUD_CNT_END=5207)
REQ-027 Single byte: write 0x55 while idle -> line low at k+2, then bits 1,0,1,0,1,0,1,0, then stop; each bit 5208 cycles, frame 52080 cycles (57288 with parity); tx_busy falls after the stop bit.
REQ-028 Burst: write 0x00,0xFF,0xA5 on consecutive cycles -> three contiguous frames, no gap, correct LSB-first order.
REQ-029 Overflow: write 10 bytes on consecutive cycles while idle -> first byte popped to shifter, next 8 fill the FIFO, fifo_full=1, 10th write dropped with a 1-cycle tx_ovf; 9 frames emitted.
REQ-030 Parity (macro defined): send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.
REQ-031 Reset mid-frame: assert s_rst_n=0 during data bit 3 -> rs232_tx=1 and tx_busy=0 within the same cycle; no further frames after release.
REQ-032 Wrap: stream 20 bytes, pacing writes so the FIFO never fills -> all 20 received intact by a UART_RX model.
